// File: rtl/aq_reduce_ctrl.sv
// Frame sequencer for aq_reduce. It shadows the scaler geometry for each frame and
// issues one frame sync per frame. It admits one frame's pixels at a time, then
// checks the returned output count and DOUT_LAST, and reports DONE and ERR.
module aq_reduce_ctrl #(
  parameter  int unsigned DRAIN_TO = 64,
  localparam int unsigned GW       = 16,
  localparam int unsigned DW       = 32,
  localparam int unsigned CW       = 32
) (
  input  logic          RST_N,
  input  logic          CLK,
  input  logic [GW-1:0] CFG_ORG_X,
  input  logic [GW-1:0] CFG_ORG_Y,
  input  logic [GW-1:0] CFG_CNV_X,
  input  logic [GW-1:0] CFG_CNV_Y,
  input  logic          START,
  input  logic          ABORT,
  input  logic          S_TVALID,
  input  logic [DW-1:0] S_TDATA,
  output logic          S_TREADY,
  output logic [GW-1:0] ORG_X,
  output logic [GW-1:0] ORG_Y,
  output logic [GW-1:0] CNV_X,
  output logic [GW-1:0] CNV_Y,
  output logic          DIN_WE,
  output logic          DIN_FSYNC,
  output logic [DW-1:0] DIN,
  input  logic          DOUT_OE,
  input  logic          DOUT_LAST,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [CW-1:0] OUT_CNT
);

  localparam int unsigned TW = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_FEED, ST_DRAIN, ST_FIN} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync_ph, w_sync_ph_nxt;
  logic [CW-1:0] r_in_cnt, w_in_cnt_nxt;
  logic [CW-1:0] r_in_total, w_in_total_nxt;
  logic [CW-1:0] r_cnv_total, w_cnv_total_nxt;
  logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
  logic [CW-1:0] r_out_cnt, w_out_cnt_nxt;
  logic          r_err, w_err_nxt;
  logic          r_done, w_done_nxt;
  logic          r_fsync, w_fsync_nxt;
  logic          r_din_we, w_din_we_nxt;
  logic [DW-1:0] r_din, w_din_nxt;
  logic          r_tready, w_tready_nxt;
  logic          r_busy, w_busy_nxt;
  logic [GW-1:0] r_org_x, r_org_y, r_cnv_x, r_cnv_y;
  logic [GW-1:0] w_org_x_nxt, w_org_y_nxt, w_cnv_x_nxt, w_cnv_y_nxt;

  logic          w_cfg_ok, w_hs, w_last_px, w_oe_en, w_drain_to, w_abort;
  logic [CW-1:0] w_out_inc;

  assign w_cfg_ok   = (CFG_CNV_X != '0) && (CFG_CNV_X <= CFG_ORG_X) &&
                      (CFG_CNV_Y != '0) && (CFG_CNV_Y <= CFG_ORG_Y);
  assign w_hs       = S_TVALID && r_tready;
  assign w_last_px  = (r_in_cnt + CW'(1)) == r_in_total;
  assign w_oe_en    = DOUT_OE && ((r_state == ST_SYNC) || (r_state == ST_FEED) ||
                                  (r_state == ST_DRAIN));
  assign w_out_inc  = r_out_cnt + CW'(w_oe_en);
  assign w_drain_to = r_to_cnt == TW'(DRAIN_TO - 1);
  assign w_abort    = ABORT && (r_state != ST_IDLE);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (START && w_cfg_ok) w_state_nxt = ST_SYNC;
        ST_SYNC:  if (r_sync_ph) w_state_nxt = ST_FEED;
        ST_FEED:  if (w_hs && w_last_px) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (DOUT_LAST || w_drain_to) w_state_nxt = ST_FIN;
        ST_FIN:   w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values of all registered outputs and datapath counters
  always_comb begin
    w_sync_ph_nxt   = r_sync_ph;
    w_in_cnt_nxt    = r_in_cnt;
    w_in_total_nxt  = r_in_total;
    w_cnv_total_nxt = r_cnv_total;
    w_to_cnt_nxt    = r_to_cnt;
    w_out_cnt_nxt   = w_out_inc;
    w_err_nxt       = r_err;
    w_done_nxt      = 1'b0;
    w_fsync_nxt     = 1'b0;
    w_din_we_nxt    = 1'b0;
    w_din_nxt       = r_din;
    w_tready_nxt    = 1'b0;
    w_busy_nxt      = w_state_nxt != ST_IDLE;
    w_org_x_nxt     = r_org_x;
    w_org_y_nxt     = r_org_y;
    w_cnv_x_nxt     = r_cnv_x;
    w_cnv_y_nxt     = r_cnv_y;
    if (w_abort) begin
      w_err_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_out_cnt_nxt = r_out_cnt;
          if (START) begin
            if (w_cfg_ok) begin
              w_org_x_nxt   = CFG_ORG_X;
              w_org_y_nxt   = CFG_ORG_Y;
              w_cnv_x_nxt   = CFG_CNV_X;
              w_cnv_y_nxt   = CFG_CNV_Y;
              w_err_nxt     = 1'b0;
              w_out_cnt_nxt = '0;
              w_in_cnt_nxt  = '0;
              w_sync_ph_nxt = 1'b0;
              w_fsync_nxt   = 1'b1;
            end else begin
              w_err_nxt  = 1'b1;
              w_done_nxt = 1'b1;
            end
          end
        end
        ST_SYNC: begin
          w_sync_ph_nxt = 1'b1;
          if (!r_sync_ph) begin
            w_in_total_nxt  = CW'(r_org_x) * CW'(r_org_y);
            w_cnv_total_nxt = CW'(r_cnv_x) * CW'(r_cnv_y);
          end else begin
            w_tready_nxt = 1'b1;
          end
        end
        ST_FEED: begin
          w_tready_nxt = 1'b1;
          if (w_hs) begin
            w_din_nxt    = S_TDATA;
            w_din_we_nxt = 1'b1;
            w_in_cnt_nxt = r_in_cnt + CW'(1);
            if (w_last_px) begin
              w_tready_nxt = 1'b0;
              w_to_cnt_nxt = '0;
            end
          end
        end
        ST_DRAIN: begin
          w_to_cnt_nxt = r_to_cnt + TW'(1);
          if (DOUT_LAST) begin
            w_done_nxt = 1'b1;
            if (w_out_inc != r_cnv_total) w_err_nxt = 1'b1;
          end else if (w_drain_to) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end
        end
        ST_FIN: w_out_cnt_nxt = r_out_cnt;
        default: ;
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync_ph   <= 1'b0;
      r_in_cnt    <= '0;
      r_in_total  <= '0;
      r_cnv_total <= '0;
      r_to_cnt    <= '0;
      r_out_cnt   <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_fsync     <= 1'b0;
      r_din_we    <= 1'b0;
      r_din       <= '0;
      r_tready    <= 1'b0;
      r_busy      <= 1'b0;
      r_org_x     <= '0;
      r_org_y     <= '0;
      r_cnv_x     <= '0;
      r_cnv_y     <= '0;
    end else begin
      r_sync_ph   <= w_sync_ph_nxt;
      r_in_cnt    <= w_in_cnt_nxt;
      r_in_total  <= w_in_total_nxt;
      r_cnv_total <= w_cnv_total_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_out_cnt   <= w_out_cnt_nxt;
      r_err       <= w_err_nxt;
      r_done      <= w_done_nxt;
      r_fsync     <= w_fsync_nxt;
      r_din_we    <= w_din_we_nxt;
      r_din       <= w_din_nxt;
      r_tready    <= w_tready_nxt;
      r_busy      <= w_busy_nxt;
      r_org_x     <= w_org_x_nxt;
      r_org_y     <= w_org_y_nxt;
      r_cnv_x     <= w_cnv_x_nxt;
      r_cnv_y     <= w_cnv_y_nxt;
    end
  end

  assign S_TREADY  = r_tready;
  assign ORG_X     = r_org_x;
  assign ORG_Y     = r_org_y;
  assign CNV_X     = r_cnv_x;
  assign CNV_Y     = r_cnv_y;
  assign DIN_WE    = r_din_we;
  assign DIN_FSYNC = r_fsync;
  assign DIN       = r_din;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERR       = r_err;
  assign OUT_CNT   = r_out_cnt;

endmodule

// File: tb/tb_aq_reduce_ctrl.sv
// Directed bench for aq_reduce_ctrl; aq_reduce is modelled by driving DOUT_OE/DOUT_LAST.
module tb_aq_reduce_ctrl;

  localparam int unsigned DRAIN_TO = 64;

  logic        RST_N = 1'b0;
  logic        CLK = 1'b0;
  logic [15:0] CFG_ORG_X = '0, CFG_ORG_Y = '0, CFG_CNV_X = '0, CFG_CNV_Y = '0;
  logic        START = 1'b0, ABORT = 1'b0, S_TVALID = 1'b0;
  logic [31:0] S_TDATA = '0;
  logic        S_TREADY;
  logic [15:0] ORG_X, ORG_Y, CNV_X, CNV_Y;
  logic        DIN_WE, DIN_FSYNC;
  logic [31:0] DIN;
  logic        DOUT_OE = 1'b0, DOUT_LAST = 1'b0;
  logic        BUSY, DONE, ERR;
  logic [31:0] OUT_CNT;

  aq_reduce_ctrl #(.DRAIN_TO(DRAIN_TO)) u_dut (
    .RST_N(RST_N), .CLK(CLK),
    .CFG_ORG_X(CFG_ORG_X), .CFG_ORG_Y(CFG_ORG_Y), .CFG_CNV_X(CFG_CNV_X), .CFG_CNV_Y(CFG_CNV_Y),
    .START(START), .ABORT(ABORT), .S_TVALID(S_TVALID), .S_TDATA(S_TDATA), .S_TREADY(S_TREADY),
    .ORG_X(ORG_X), .ORG_Y(ORG_Y), .CNV_X(CNV_X), .CNV_Y(CNV_Y),
    .DIN_WE(DIN_WE), .DIN_FSYNC(DIN_FSYNC), .DIN(DIN),
    .DOUT_OE(DOUT_OE), .DOUT_LAST(DOUT_LAST),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .OUT_CNT(OUT_CNT)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0;
  int          n_err = 0;
  int          m_fsync = 0, m_we = 0, m_done = 0;
  logic [31:0] m_din_q[$];
  logic [31:0] data_base;

  // Output event monitor, sampled mid-cycle
  always @(negedge CLK) begin
    if (RST_N) begin
      if (DIN_FSYNC) m_fsync++;
      if (DONE) m_done++;
      if (DIN_WE) begin
        m_we++;
        m_din_q.push_back(DIN);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tready"}, 32'(S_TREADY), 0);
    chk({tag, "_geom"}, {ORG_X | ORG_Y, CNV_X | CNV_Y}, 0);
    chk({tag, "_we_fs"}, {30'd0, DIN_WE, DIN_FSYNC}, 0);
    chk({tag, "_din"}, DIN, 0);
    chk({tag, "_bde"}, {29'd0, BUSY, DONE, ERR}, 0);
    chk({tag, "_outcnt"}, OUT_CNT, 0);
  endtask

  // One frame: START, feed pixels, then return n_oe output strobes in DRAIN
  task automatic run_frame(input logic [15:0] ox, input logic [15:0] oy,
                           input logic [15:0] cx, input logic [15:0] cy,
                           input bit toggle, input int n_oe, input bit give_last,
                           input int abort_at, input int mstart_at,
                           output int lat, output int hs);
    int  tot;
    bit  rdy, ab, ms, ms_done;
    tot = int'(ox) * int'(oy);
    hs = 0; lat = -1; ms_done = 0;
    CFG_ORG_X = ox; CFG_ORG_Y = oy; CFG_CNV_X = cx; CFG_CNV_Y = cy;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("start_fsync", {30'd0, DIN_FSYNC, BUSY}, 32'h3);
    chk("start_err_clr", {30'd0, ERR, S_TREADY}, 0);
    chk("start_org_x", 32'(ORG_X), 32'(ox));
    for (int cyc = 0; cyc < 2000 && hs < tot; cyc++) begin
      S_TVALID = toggle ? (cyc % 2 == 0) : 1'b1;
      S_TDATA  = data_base + 32'(hs);
      rdy = S_TREADY;
      ab  = (abort_at > 0) && (hs == abort_at - 1) && S_TVALID && rdy;
      ms  = (mstart_at > 0) && (hs == mstart_at) && !ms_done;
      ABORT = ab;
      if (ms) begin
        START = 1'b1;
        CFG_ORG_X = ox + 16'd4;
      end
      tick();
      START = 1'b0;
      if (ms) begin
        ms_done = 1;
        chk("mid_org_x_hold", 32'(ORG_X), 32'(ox));
        chk("mid_busy", 32'(BUSY), 1);
      end
      if (ab) begin
        ABORT = 1'b0;
        S_TVALID = 1'b0;
        return;
      end
      if (S_TVALID && rdy) hs++;
    end
    S_TVALID = 1'b0;
    if (hs < tot) begin
      chk("feed_timeout", 32'(hs), 32'(tot));
      return;
    end
    for (int i = 0; i < 200; i++) begin
      DOUT_OE   = i < n_oe;
      DOUT_LAST = give_last && (i == n_oe - 1);
      tick();
      if (DONE) begin
        lat = i + 1;
        break;
      end
    end
    DOUT_OE = 1'b0;
    DOUT_LAST = 1'b0;
  endtask

  // Checks common to a completed frame
  task automatic chk_frame(input string tag, input int f0, input int w0, input int d0, input int q0,
                           input int exp_we, input int lat, input int exp_lat,
                           input logic [31:0] exp_cnt, input logic exp_err);
    int mism;
    chk({tag, "_fsync"}, 32'(m_fsync - f0), 1);
    chk({tag, "_we"}, 32'(m_we - w0), 32'(exp_we));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_outcnt"}, OUT_CNT, exp_cnt);
    chk({tag, "_err"}, 32'(ERR), 32'(exp_err));
    mism = 0;
    for (int i = 0; i < exp_we; i++)
      if (q0 + i >= m_din_q.size() || m_din_q[q0 + i] !== data_base + 32'(i)) mism++;
    chk({tag, "_din_order"}, 32'(mism), 0);
    tick();
    chk({tag, "_idle"}, {30'd0, BUSY, DONE}, 0);
    chk({tag, "_done_cnt"}, 32'(m_done - d0), 1);
  endtask

  initial begin
    int f0, w0, d0, q0, lat, hs;
    tick();
    chk_zero("rst_hold");
    RST_N = 1'b1;
    tick();
    chk_zero("rst_rel");

    // 1: 4x4 -> 2x2, valid held high
    data_base = 32'hA100_0000;
    f0 = m_fsync; w0 = m_we; d0 = m_done; q0 = m_din_q.size();
    run_frame(16'd4, 16'd4, 16'd2, 16'd2, 0, 4, 1, 0, 0, lat, hs);
    chk_frame("t1", f0, w0, d0, q0, 16, lat, 4, 4, 1'b0);

    // 2: same frame, valid toggling
    data_base = 32'hB200_0000;
    f0 = m_fsync; w0 = m_we; d0 = m_done; q0 = m_din_q.size();
    run_frame(16'd4, 16'd4, 16'd2, 16'd2, 1, 4, 1, 0, 0, lat, hs);
    chk_frame("t2", f0, w0, d0, q0, 16, lat, 4, 4, 1'b0);

    // 2b: CNV equal to ORG, one output short -> count error
    data_base = 32'hC300_0000;
    f0 = m_fsync; w0 = m_we; d0 = m_done; q0 = m_din_q.size();
    run_frame(16'd2, 16'd2, 16'd2, 16'd2, 0, 3, 1, 0, 0, lat, hs);
    chk_frame("t2b", f0, w0, d0, q0, 4, lat, 3, 3, 1'b1);

    // 3: invalid geometry CNV_X > ORG_X
    f0 = m_fsync;
    CFG_ORG_X = 16'd4; CFG_ORG_Y = 16'd4; CFG_CNV_X = 16'd5; CFG_CNV_Y = 16'd2;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("t3_err_done", {29'd0, ERR, DONE, BUSY}, 32'h6);
    tick();
    chk("t3_after", {29'd0, ERR, DONE, BUSY}, 32'h4);
    chk("t3_no_fsync", 32'(m_fsync - f0), 0);

    // 4: CFG change and START mid-FEED are ignored; next frame picks up new width
    data_base = 32'hD400_0000;
    f0 = m_fsync; w0 = m_we; d0 = m_done; q0 = m_din_q.size();
    run_frame(16'd4, 16'd4, 16'd2, 16'd2, 0, 4, 1, 0, 5, lat, hs);
    chk_frame("t4a", f0, w0, d0, q0, 16, lat, 4, 4, 1'b0);
    data_base = 32'hD500_0000;
    f0 = m_fsync; w0 = m_we; d0 = m_done; q0 = m_din_q.size();
    run_frame(16'd8, 16'd4, 16'd2, 16'd2, 0, 4, 1, 0, 0, lat, hs);
    chk_frame("t4b", f0, w0, d0, q0, 32, lat, 4, 4, 1'b0);

    // 5: DOUT_LAST never arrives -> timeout
    data_base = 32'hE600_0000;
    f0 = m_fsync; w0 = m_we; d0 = m_done; q0 = m_din_q.size();
    run_frame(16'd2, 16'd2, 16'd1, 16'd1, 0, 1, 0, 0, 0, lat, hs);
    chk_frame("t5", f0, w0, d0, q0, 4, lat, DRAIN_TO, 1, 1'b1);

    // 6: ABORT on pixel 7, then reset
    data_base = 32'hF700_0000;
    w0 = m_we; d0 = m_done;
    run_frame(16'd4, 16'd4, 16'd2, 16'd2, 0, 0, 0, 7, 0, lat, hs);
    chk("t6_hs", 32'(hs), 6);
    chk("t6_abort", {28'd0, BUSY, S_TREADY, DIN_WE, ERR}, 32'h1);
    repeat (5) tick();
    chk("t6_we", 32'(m_we - w0), 6);
    chk("t6_no_done", 32'(m_done - d0), 0);
    RST_N = 1'b0;
    #2;
    chk_zero("t6_rst");
    RST_N = 1'b1;
    tick();
    chk_zero("t6_rel");

    // 6b: asynchronous reset in the middle of FEED
    f0 = m_fsync; d0 = m_done;
    CFG_ORG_X = 16'd4; CFG_ORG_Y = 16'd4; CFG_CNV_X = 16'd2; CFG_CNV_Y = 16'd2;
    START = 1'b1;
    tick();
    START = 1'b0;
    S_TVALID = 1'b1;
    repeat (5) tick();
    chk("t6b_busy", {30'd0, BUSY, S_TREADY}, 32'h3);
    #2;
    RST_N = 1'b0;
    #1;
    chk_zero("t6b_rst");
    S_TVALID = 1'b0;
    #1;
    RST_N = 1'b1;
    repeat (4) tick();
    chk_zero("t6b_rel");
    chk("t6b_no_fsync_done", 32'((m_fsync - f0) + (m_done - d0)), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
